// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000-style asynchronous bus slave backed by a word-wide RAM.
// DTACK follows recognition by WAIT_STATES+1 cycles; accesses outside the window raise BERR.
module m68k_bus_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [22:0] BASE_WORD   = 23'h000000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [22:0] A,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        DTACK,
  output logic        BERR
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t               state_reg;
  logic [3:0]           wait_cnt_reg;
  logic [ADDR_BITS-1:0] index_reg;
  logic                 rw_reg;
  logic [1:0]           strobe_n_reg;  // [1] = UDS, [0] = LDS, as sampled at recognition
  logic                 dtack_reg;
  logic                 berr_reg;
  logic                 d_oe_reg;

  logic [22:0] offset;
  logic        in_range;
  logic        cycle_start;
  logic        ack_entry;

  // Offset wraps mod 2^23, so a window near the top of the map still decodes correctly.
  assign offset      = A - BASE_WORD;
  assign in_range    = (offset >> ADDR_BITS) == 23'd0;
  assign cycle_start = !AS && (!UDS || !LDS);
  assign ack_entry   = !RESET && (state_reg == S_WAIT) && !AS && (wait_cnt_reg == 4'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      dtack_reg    <= 1'b0;
      berr_reg     <= 1'b0;
      d_oe_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cycle_start) begin
            index_reg    <= offset[ADDR_BITS-1:0];
            rw_reg       <= RW;
            strobe_n_reg <= {UDS, LDS};
            if (in_range) begin
              wait_cnt_reg <= 4'(WAIT_STATES);
              state_reg    <= S_WAIT;
            end else begin
              state_reg <= S_ERR;
            end
          end
        end
        S_WAIT: begin
          if (AS) begin
            state_reg <= S_IDLE;
          end else if (wait_cnt_reg == 4'd0) begin
            state_reg <= S_ACK;
            dtack_reg <= 1'b1;
            d_oe_reg  <= rw_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        S_ACK: begin
          if (AS) begin
            dtack_reg <= 1'b0;
            d_oe_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        S_ERR: begin
          if (AS) begin
            berr_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            berr_reg <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign DTACK = dtack_reg;
  assign BERR  = berr_reg;
  assign D_OE  = d_oe_reg;

  // One byte-wide RAM per lane so each strobe maps to an independent write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge CLK) begin
        if (ack_entry && !rw_reg && !strobe_n_reg[gi]) begin
          mem[index_reg] <= D_IN[gi*8 +: 8];
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          rd_reg <= 8'h00;
        end else if (ack_entry && rw_reg) begin
          rd_reg <= mem[index_reg];
        end
      end

      assign D_OUT[gi*8 +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: two instances (2 and 0 wait states) share one random bus master
// and are checked every cycle against a transaction-age reference model plus directed literals.
module tb_m68k_bus_responder;

  localparam int          DEPTH = 1024;
  localparam logic [22:0] BASE  = 23'h000000;

  logic        CLK;
  logic        RESET;
  logic [22:0] A;
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic [15:0] D_IN;

  logic [15:0] dut_dout [2];
  logic [1:0]  dut_oe;
  logic [1:0]  dut_dtack;
  logic [1:0]  dut_berr;

  m68k_bus_responder #(.ADDR_BITS(10), .BASE_WORD(BASE), .WAIT_STATES(2)) u_ws2 (
    .CLK(CLK), .RESET(RESET), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .D_IN(D_IN),
    .D_OUT(dut_dout[0]), .D_OE(dut_oe[0]), .DTACK(dut_dtack[0]), .BERR(dut_berr[0])
  );

  m68k_bus_responder #(.ADDR_BITS(10), .BASE_WORD(BASE), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .RESET(RESET), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .D_IN(D_IN),
    .D_OUT(dut_dout[1]), .D_OE(dut_oe[1]), .DTACK(dut_dtack[1]), .BERR(dut_berr[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    chk(nm, {15'd0, act}, {15'd0, exp});
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Reference model: a cycle is "age" edges old; DTACK arrives at age ws+1, BERR at age 1,
  // and any edge with AS high ends the cycle.
  logic [15:0] m_mem [2][DEPTH];
  logic [1:0]  m_kn  [2][DEPTH];
  bit          m_act [2];
  bit          m_err [2];
  bit          m_rw  [2];
  bit [1:0]    m_sn  [2];
  int          m_age [2];
  int          m_idx [2];
  bit          m_dt  [2];
  bit          m_be  [2];
  bit          m_oe  [2];
  logic [15:0] m_do  [2];
  logic [15:0] m_dmask [2];

  task automatic model_step(input int k);
    logic [22:0] off;
    if (RESET) begin
      m_act[k] = 1'b0; m_dt[k] = 1'b0; m_be[k] = 1'b0; m_oe[k] = 1'b0;
      m_do[k] = 16'h0000; m_dmask[k] = 16'hFFFF;
    end else if (!m_act[k]) begin
      if (!AS && (!UDS || !LDS)) begin
        off = A - BASE;
        m_act[k] = 1'b1;
        m_age[k] = 0;
        m_err[k] = (off >= 23'd1024);
        m_idx[k] = int'(off[9:0]);
        m_rw[k]  = RW;
        m_sn[k]  = {UDS, LDS};
      end
    end else begin
      m_age[k]++;
      if (AS) begin
        m_act[k] = 1'b0; m_dt[k] = 1'b0; m_be[k] = 1'b0; m_oe[k] = 1'b0;
      end else if (m_err[k]) begin
        m_be[k] = 1'b1;
      end else if (m_age[k] == ws_of(k) + 1) begin
        m_dt[k] = 1'b1;
        m_oe[k] = m_rw[k];
        if (m_rw[k]) begin
          m_do[k]    = m_mem[k][m_idx[k]];
          m_dmask[k] = {{8{m_kn[k][m_idx[k]][1]}}, {8{m_kn[k][m_idx[k]][0]}}};
        end else begin
          if (!m_sn[k][1]) begin
            m_mem[k][m_idx[k]][15:8] = D_IN[15:8];
            m_kn[k][m_idx[k]][1] = 1'b1;
          end
          if (!m_sn[k][0]) begin
            m_mem[k][m_idx[k]][7:0] = D_IN[7:0];
            m_kn[k][m_idx[k]][0] = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_dt[k] = 1'b0; m_be[k] = 1'b0; m_oe[k] = 1'b0;
      m_do[k] = 16'h0000; m_dmask[k] = 16'hFFFF;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[k][i] = 16'h0000;
        m_kn[k][i]  = 2'b00;
      end
    end
    forever begin
      @(posedge CLK);
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (check_en) begin
        for (int k = 0; k < 2; k++) begin
          chk_b($sformatf("ws%0d_dtack", ws_of(k)), dut_dtack[k], m_dt[k]);
          chk_b($sformatf("ws%0d_berr", ws_of(k)), dut_berr[k], m_be[k]);
          chk_b($sformatf("ws%0d_d_oe", ws_of(k)), dut_oe[k], m_oe[k]);
          if (m_oe[k] && m_dmask[k] != 16'h0000)
            chk($sformatf("ws%0d_d_out", ws_of(k)), dut_dout[k] & m_dmask[k], m_do[k] & m_dmask[k]);
        end
      end
    end
  end

  logic [1:0]  rec_dt [16];
  logic [1:0]  rec_be [16];
  logic [1:0]  rec_oe [16];
  logic [15:0] rec_do [16][2];

  task automatic rec(input int i);
    rec_dt[i] = dut_dtack;
    rec_be[i] = dut_berr;
    rec_oe[i] = dut_oe;
    rec_do[i][0] = dut_dout[0];
    rec_do[i][1] = dut_dout[1];
  endtask

  // Holds AS low for 'hold' edges, then releases for one edge; rec[i] is the view after edge i.
  task automatic run_cycle(input logic [22:0] a, input logic rw, input logic u, input logic l,
                           input logic [15:0] d, input int hold);
    A = a; RW = rw; UDS = u; LDS = l; D_IN = d; AS = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      rec(i);
    end
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    @(negedge CLK);
    rec(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [22:0] a;
    int          sel;
    int          hold;
    int          gap;

    RESET = 1'b1; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; A = 23'h0; D_IN = 16'h0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk_b("idle_dtack", dut_dtack[0], 1'b0);
      chk_b("idle_berr", dut_berr[0], 1'b0);
      chk_b("idle_d_oe", dut_oe[0], 1'b0);
    end

    // Word write, then read back.
    run_cycle(23'h000010, 1'b0, 1'b0, 1'b0, 16'hBEEF, 5);
    chk_b("wr_dtack_e2", rec_dt[2][0], 1'b0);
    chk_b("wr_dtack_e3", rec_dt[3][0], 1'b1);
    chk_b("wr_d_oe_e3", rec_oe[3][0], 1'b0);
    chk_b("wr_release", rec_dt[5][0], 1'b0);
    chk_b("ws0_wr_dtack_e0", rec_dt[0][1], 1'b0);
    chk_b("ws0_wr_dtack_e1", rec_dt[1][1], 1'b1);
    run_cycle(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 5);
    chk_b("rd_dtack_e3", rec_dt[3][0], 1'b1);
    chk_b("rd_d_oe_e3", rec_oe[3][0], 1'b1);
    chk("rd_beef", rec_do[3][0], 16'hBEEF);
    chk("ws0_rd_beef", rec_do[1][1], 16'hBEEF);

    // Byte lanes.
    run_cycle(23'h000010, 1'b0, 1'b0, 1'b1, 16'h12AA, 5);
    run_cycle(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 5);
    chk("upper_lane", rec_do[3][0], 16'h12EF);
    run_cycle(23'h000010, 1'b0, 1'b1, 1'b0, 16'hFF34, 5);
    run_cycle(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 5);
    chk("lower_lane", rec_do[3][0], 16'h1234);

    // Out of range write aliasing onto index 0 must not touch RAM.
    run_cycle(23'h000000, 1'b0, 1'b0, 1'b0, 16'h0A0B, 5);
    run_cycle(23'h000400, 1'b0, 1'b0, 1'b0, 16'h5555, 4);
    chk_b("oor_berr_e1", rec_be[1][0], 1'b1);
    chk_b("oor_dtack_e3", rec_dt[3][0], 1'b0);
    chk_b("oor_release", rec_be[4][0], 1'b0);
    chk_b("ws0_oor_berr_e1", rec_be[1][1], 1'b1);
    run_cycle(23'h000000, 1'b1, 1'b0, 1'b0, 16'h0000, 5);
    chk("oor_ram_kept", rec_do[3][0], 16'h0A0B);

    // Abort in WAIT: the 2-wait instance drops the write, the 0-wait one has already acked.
    run_cycle(23'h000020, 1'b0, 1'b0, 1'b0, 16'h1111, 5);
    run_cycle(23'h000020, 1'b0, 1'b0, 1'b0, 16'h2222, 2);
    chk_b("abort_dtack_e1", rec_dt[1][0], 1'b0);
    chk_b("abort_dtack_e2", rec_dt[2][0], 1'b0);
    chk_b("ws0_short_dtack", rec_dt[1][1], 1'b1);
    run_cycle(23'h000020, 1'b1, 1'b0, 1'b0, 16'h0000, 5);
    chk("abort_ram_kept", rec_do[3][0], 16'h1111);
    chk("ws0_short_write", rec_do[3][1], 16'h2222);

    // AS low with both strobes high is not a bus cycle.
    A = 23'h000010; RW = 1'b1; UDS = 1'b1; LDS = 1'b1; AS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk_b("nostrobe_dtack", dut_dtack[0], 1'b0);
      chk_b("nostrobe_berr", dut_berr[0], 1'b0);
    end
    AS = 1'b1;
    @(negedge CLK);

    // Reset while in ACK.
    A = 23'h000010; RW = 1'b1; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
    repeat (4) @(negedge CLK);
    chk_b("pre_reset_dtack", dut_dtack[0], 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    chk_b("reset_ack_dtack", dut_dtack[0], 1'b0);
    chk_b("reset_ack_d_oe", dut_oe[0], 1'b0);
    RESET = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    @(negedge CLK);
    run_cycle(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 5);
    chk("post_reset_read", rec_do[3][0], 16'h1234);

    // Back-to-back zero-wait reads with a single idle cycle between them.
    run_cycle(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 2);
    chk_b("b2b_first_dtack_e0", rec_dt[0][1], 1'b0);
    chk_b("b2b_first_dtack_e1", rec_dt[1][1], 1'b1);
    chk("b2b_first_data", rec_do[1][1], 16'h1234);
    run_cycle(23'h000020, 1'b1, 1'b0, 1'b0, 16'h0000, 2);
    chk_b("b2b_second_dtack_e1", rec_dt[1][1], 1'b1);
    chk("b2b_second_data", rec_do[1][1], 16'h2222);

    // Random traffic: aborts, out-of-range, strobe/address changes and resets mid-cycle.
    for (int t = 0; t < 400; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = 23'($urandom_range(0, 15));
      else if (sel == 7) a = 23'h000400 + 23'($urandom_range(0, 15));
      else if (sel == 8) a = 23'h7FFFF0 + 23'($urandom_range(0, 15));
      else               a = 23'($urandom_range(0, 1023));
      hold = int'($urandom_range(1, 7));
      gap  = int'($urandom_range(1, 3));
      A = a; RW = 1'($urandom_range(0, 1)); UDS = 1'($urandom_range(0, 1));
      LDS = 1'($urandom_range(0, 1)); D_IN = 16'($urandom); AS = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        if ($urandom_range(0, 9) == 0) begin
          A = 23'($urandom_range(0, 15)); RW = 1'($urandom_range(0, 1));
          UDS = 1'($urandom_range(0, 1)); LDS = 1'($urandom_range(0, 1)); D_IN = 16'($urandom);
        end
        RESET = ($urandom_range(0, 59) == 0);
      end
      RESET = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
      for (int i = 0; i < gap; i++) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
